// File: rtl/ahbl_regfile_pkg.sv
// ahbl_regfile_pkg
//   Shared AHB-Lite encodings and FSM state type for the register-file slave.
//   HTRANS_*  : transfer types (only HTRANS[1]=1 starts a transfer)
//   HSIZE_*   : byte / halfword / word transfer sizes
//   HRESP_*   : OKAY / ERROR response codes
//   state_e   : data-phase FSM states
package ahbl_regfile_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_DATA = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } state_e;

endpackage

// File: rtl/ahbl_regfile_byte_strobe.sv
// ahbl_regfile_byte_strobe
//   Combinational byte-lane decode for an AHB-Lite transfer.
//   i_size     in  3  HSIZE of the transfer
//   i_addr     in  2  HADDR[1:0] of the transfer
//   o_mask     out 4  byte lanes touched (bit b = HWDATA[8b +: 8])
//   o_misalign out 1  halfword on odd address or word not on a 4-byte boundary
//   Sizes above word give an empty mask; the caller flags those separately.
module ahbl_regfile_byte_strobe
    import ahbl_regfile_pkg::*;
(
    input  logic [2:0] i_size,
    input  logic [1:0] i_addr,
    output logic [3:0] o_mask,
    output logic       o_misalign
);

    always_comb begin
        o_mask     = 4'b0000;
        o_misalign = 1'b0;
        case (i_size)
            HSIZE_BYTE: o_mask = 4'b0001 << i_addr;
            HSIZE_HALF: begin
                o_mask     = i_addr[1] ? 4'b1100 : 4'b0011;
                o_misalign = i_addr[0];
            end
            HSIZE_WORD: begin
                o_mask     = 4'b1111;
                o_misalign = |i_addr;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/ahbl_regfile.sv
// ahbl_regfile
//   Parametrised AHB-Lite slave register file with byte/halfword writes,
//   read-only status registers, optional wait states and ERROR responses.
//   HCLK/HRESETn        clock, async active-low reset
//   HSEL,HADDR,HTRANS,
//   HWRITE,HSIZE,HREADY address-phase inputs
//   HWDATA              write data (data phase)
//   HREADYOUT,HRESP,
//   HRDATA              data-phase response
//   regs_o              register contents, reg i at [32*i +: 32]
//   regs_i              status values returned for read-only registers
//   wr_pulse_o          high for the cycle whose clock edge commits a write to reg i
module ahbl_regfile
    import ahbl_regfile_pkg::*;
#(
    parameter int                  NUM_REGS    = 8,
    parameter int                  IDX_LSB     = 2,
    parameter int                  WAIT_STATES = 0,
    parameter logic [NUM_REGS-1:0] RO_MASK     = '0,
    parameter logic [31:0]         ID          = 32'hABCD_EF01
) (
    input  logic                    HCLK,
    input  logic                    HRESETn,
    input  logic                    HSEL,
    input  logic [31:0]             HADDR,
    input  logic [1:0]              HTRANS,
    input  logic                    HWRITE,
    input  logic [2:0]              HSIZE,
    input  logic                    HREADY,
    input  logic [31:0]             HWDATA,
    output logic                    HREADYOUT,
    output logic                    HRESP,
    output logic [31:0]             HRDATA,
    output logic [32*NUM_REGS-1:0]  regs_o,
    input  logic [32*NUM_REGS-1:0]  regs_i,
    output logic [NUM_REGS-1:0]     wr_pulse_o
);

    // One extra index bit so that index NUM_REGS decodes as out of range
    // instead of aliasing onto register 0.
    localparam int IDX_W = $clog2(NUM_REGS + 1);

    state_e                    r_state, w_state_nxt, w_path;
    logic [3:0]                r_cnt;
    logic [IDX_W-1:0]          r_idx;
    logic [3:0]                r_mask;
    logic                      r_write;
    logic [NUM_REGS-1:0][31:0] r_regs;

    logic [IDX_W-1:0] w_idx;
    logic [3:0]       w_mask;
    logic             w_misalign, w_ro_hit, w_bad, w_accept;
    logic             w_unused;

    assign w_idx    = HADDR[IDX_LSB +: IDX_W];
    assign w_unused = ^{HADDR, regs_i, ID};

    ahbl_regfile_byte_strobe u_strobe (
        .i_size     (HSIZE),
        .i_addr     (HADDR[1:0]),
        .o_mask     (w_mask),
        .o_misalign (w_misalign)
    );

    always_comb begin
        w_ro_hit = 1'b0;
        for (int i = 0; i < NUM_REGS; i++)
            if (RO_MASK[i] && (w_idx == IDX_W'(i))) w_ro_hit = 1'b1;
    end

    // New address phases are only taken while this slave is itself ready,
    // so a stray HREADY during WAIT/ERR1 cannot corrupt the transfer in flight.
    assign w_accept = HSEL & HREADY & HTRANS[1] & HREADYOUT;
    assign w_bad    = (w_idx >= IDX_W'(NUM_REGS)) | (HSIZE > HSIZE_WORD)
                    | w_misalign | (HWRITE & w_ro_hit);
    assign w_path   = w_bad ? ST_ERR1 : ((WAIT_STATES > 0) ? ST_WAIT : ST_DATA);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_DATA, ST_ERR2: w_state_nxt = w_accept ? w_path : ST_IDLE;
            ST_WAIT:                   if (r_cnt == 4'd0) w_state_nxt = ST_DATA;
            ST_ERR1:                   w_state_nxt = ST_ERR2;
            default:                   w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_mask  <= '0;
            r_write <= 1'b0;
            r_regs  <= '0;
        end else begin
            r_state <= w_state_nxt;
            // Counter preloads to WAIT_STATES-1 so WAIT lasts exactly WAIT_STATES cycles.
            if (w_accept) begin
                r_idx   <= w_idx;
                r_mask  <= w_mask;
                r_write <= HWRITE;
                r_cnt   <= 4'(WAIT_STATES - 1);
            end else if ((r_state == ST_WAIT) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if ((r_state == ST_DATA) && r_write) begin
                for (int i = 0; i < NUM_REGS; i++)
                    if (!RO_MASK[i] && (r_idx == IDX_W'(i)))
                        for (int b = 0; b < 4; b++)
                            if (r_mask[b]) r_regs[i][8*b +: 8] <= HWDATA[8*b +: 8];
            end
        end
    end

    always_comb begin
        HREADYOUT  = !((r_state == ST_WAIT) || (r_state == ST_ERR1));
        HRESP      = ((r_state == ST_ERR1) || (r_state == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
        HRDATA     = '0;
        wr_pulse_o = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if ((r_state == ST_DATA) && (r_idx == IDX_W'(i))) begin
                if (r_write) wr_pulse_o[i] = 1'b1;
                else         HRDATA = RO_MASK[i] ? regs_i[32*i +: 32] : r_regs[i];
            end
        end
    end

    assign regs_o = r_regs;

endmodule
